// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared types for the Nandgame CPU run controller:
//   ctrl_state_t     - controller state, also exported on state_o
//   ctrl_req_t       - a single button request after priority resolution
//   resolve_request  - picks one request when several arrive together
//                      (restart > halt > step > run)
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    HALT       = 2'd1,
    RUN        = 2'd2,
    STEP       = 2'd3
  } ctrl_state_t;

  // A higher encoding means a higher priority.
  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_RUN     = 3'd1,
    REQ_STEP    = 3'd2,
    REQ_HALT    = 3'd3,
    REQ_RESTART = 3'd4
  } ctrl_req_t;

  // Only the winning request survives. Any lower-priority request arriving
  // in the same cycle is lost rather than queued.
  function automatic ctrl_req_t resolve_request(input logic restart,
                                                input logic halt,
                                                input logic step,
                                                input logic run);
    ctrl_req_t req;
    req = REQ_NONE;
    if (restart)   req = REQ_RESTART;
    else if (halt) req = REQ_HALT;
    else if (step) req = REQ_STEP;
    else if (run)  req = REQ_RUN;
    return req;
  endfunction

endpackage

// File: rtl/cpu_run_controller_btn_edge.sv
// btn_edge
// Synchronises a raw board button into the clk domain and emits a single
// one-cycle pulse for each rising edge. The pulse is registered, so it
// appears three clk edges after the raw edge. Holding the button produces
// only one pulse.
// Ports:
//   clk           system clock
//   n_sync_reset  synchronous active-low reset
//   btn_i         raw, asynchronous button level
//   pulse_o       registered one-cycle request pulse
module btn_edge (
  input  logic clk,
  input  logic n_sync_reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync_q1;
  logic sync_q2;
  logic level_q;

  // sync_q1/sync_q2 form the metastability chain. level_q remembers the
  // previous synchronised level so that only a 0->1 change fires a pulse.
  always_ff @(posedge clk) begin
    if (!n_sync_reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
      level_q <= sync_q2;
      pulse_o <= sync_q2 & ~level_q;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences the Nandgame CPU core: produces the core clock enable and the
// core PC reset, and implements HALT / RUN / STEP / RESTART from the board
// buttons, a divided run rate, and a single PC breakpoint.
// Parameters:
//   RESET_CYCLES  cycles cpu_reset_o is held on entry to RESET_HOLD (>=1)
//   RATE_DIV      RUN issues one ce slot every RATE_DIV cycles (>=1)
//   AUTO_RUN      1: RESET_HOLD -> RUN, 0: RESET_HOLD -> HALT
// Ports:
//   clk, n_sync_reset        clock and synchronous active-low reset
//   run/step/halt/restart_btn_i  raw buttons, rising edge = request
//   pc_i                     current core PC
//   bp_en_i, bp_addr_i       breakpoint enable and address
//   cpu_ce_o                 core clock enable (registered)
//   cpu_reset_o              core pc_reset, active-high (registered)
//   state_o                  ctrl_state_t encoding
//   bp_hit_o                 sticky breakpoint-hit flag
//   step_count_o             number of non-reset ce pulses, wraps
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int RATE_DIV     = 1000,
  parameter bit AUTO_RUN     = 1'b0
) (
  input  logic        clk,
  input  logic        n_sync_reset,
  input  logic        run_btn_i,
  input  logic        step_btn_i,
  input  logic        halt_btn_i,
  input  logic        restart_btn_i,
  input  logic [15:0] pc_i,
  input  logic        bp_en_i,
  input  logic [15:0] bp_addr_i,
  output logic        cpu_ce_o,
  output logic        cpu_reset_o,
  output logic [1:0]  state_o,
  output logic        bp_hit_o,
  output logic [15:0] step_count_o
);

  localparam int PS_W   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(RATE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  ctrl_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PS_W-1:0]   prescaler;
  logic              skip_bp;

  logic      run_req;
  logic      step_req;
  logic      halt_req;
  logic      restart_req;
  ctrl_req_t req;
  logic      bp_match;

  btn_edge u_run_edge (
    .clk          (clk),
    .n_sync_reset (n_sync_reset),
    .btn_i        (run_btn_i),
    .pulse_o      (run_req)
  );

  btn_edge u_step_edge (
    .clk          (clk),
    .n_sync_reset (n_sync_reset),
    .btn_i        (step_btn_i),
    .pulse_o      (step_req)
  );

  btn_edge u_halt_edge (
    .clk          (clk),
    .n_sync_reset (n_sync_reset),
    .btn_i        (halt_btn_i),
    .pulse_o      (halt_req)
  );

  btn_edge u_restart_edge (
    .clk          (clk),
    .n_sync_reset (n_sync_reset),
    .btn_i        (restart_btn_i),
    .pulse_o      (restart_req)
  );

  assign req = resolve_request(restart_req, halt_req, step_req, run_req);

  // skip_bp lets the instruction sitting on the breakpoint execute once
  // after the user resumes, otherwise RUN would stop again immediately.
  assign bp_match = bp_en_i && (pc_i == bp_addr_i) && !skip_bp;

  assign state_o = state;

  // A restart request behaves exactly like the hardware reset. Both put the
  // core back into a fresh hold period and clear the counters.
  always_ff @(posedge clk) begin
    if (!n_sync_reset || (req == REQ_RESTART)) begin
      state        <= RESET_HOLD;
      hold_cnt     <= '0;
      cpu_reset_o  <= 1'b1;
      cpu_ce_o     <= 1'b1;
      bp_hit_o     <= 1'b0;
      step_count_o <= '0;
      prescaler    <= '0;
      skip_bp      <= 1'b0;
    end else begin
      case (state)
        RESET_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            cpu_reset_o <= 1'b0;
            cpu_ce_o    <= 1'b0;
            prescaler   <= '0;
            state       <= AUTO_RUN ? RUN : HALT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        HALT: begin
          cpu_ce_o  <= 1'b0;
          prescaler <= '0;
          if (req == REQ_STEP) begin
            state        <= STEP;
            skip_bp      <= 1'b1;
            bp_hit_o     <= 1'b0;
            cpu_ce_o     <= 1'b1;
            step_count_o <= step_count_o + 16'd1;
          end else if (req == REQ_RUN) begin
            state    <= RUN;
            skip_bp  <= 1'b1;
            bp_hit_o <= 1'b0;
          end
        end

        // The single ce cycle was issued on entry, so STEP only drops it.
        STEP: begin
          cpu_ce_o <= 1'b0;
          state    <= HALT;
        end

        RUN: begin
          if (req == REQ_HALT) begin
            // A ce slot that coincides with the halt request is dropped.
            state     <= HALT;
            cpu_ce_o  <= 1'b0;
            prescaler <= '0;
          end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            if (bp_match) begin
              cpu_ce_o <= 1'b0;
              bp_hit_o <= 1'b1;
              state    <= HALT;
            end else begin
              cpu_ce_o     <= 1'b1;
              step_count_o <= step_count_o + 16'd1;
              skip_bp      <= 1'b0;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
            cpu_ce_o  <= 1'b0;
          end
        end

        default: begin
          state    <= HALT;
          cpu_ce_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller
// Self-checking bench for cpu_run_controller.
//   dut1: RESET_CYCLES=4, RATE_DIV=5, AUTO_RUN=0. Exercises the reset hold,
//         step, run, breakpoint, priority and restart behaviour. Every
//         non-reset ce pulse it issues is matched against a scoreboard of
//         expected (cycle, step_count) entries.
//   dut2/dut3: RATE_DIV=1, AUTO_RUN=1. They run together so that one pass
//         to 16'hFFFF covers both the counter wrap (dut2) and a reset
//         asserted mid-RUN (dut3).
module tb_cpu_run_controller;

  localparam logic [3:0] B_RUN     = 4'b0001;
  localparam logic [3:0] B_STEP    = 4'b0010;
  localparam logic [3:0] B_HALT    = 4'b0100;
  localparam logic [3:0] B_RESTART = 4'b1000;

  logic        clk = 1'b0;
  logic        n_sync_reset;
  logic        run_btn;
  logic        step_btn;
  logic        halt_btn;
  logic        restart_btn;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [15:0] pc;

  logic        ce1;
  logic        rst1;
  logic [1:0]  state1;
  logic        bp_hit1;
  logic [15:0] count1;

  logic        n_sync_reset2;
  logic        n_sync_reset3;
  logic        idle_btn;
  logic        idle_bp_en;
  logic [15:0] zero16;

  logic        ce2, rst2, bp_hit2;
  logic [1:0]  state2;
  logic [15:0] count2;
  logic        ce3, rst3, bp_hit3;
  logic [1:0]  state3;
  logic [15:0] count3;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_count;

  cpu_run_controller #(.RESET_CYCLES(4), .RATE_DIV(5), .AUTO_RUN(1'b0)) dut1 (
    .clk           (clk),
    .n_sync_reset  (n_sync_reset),
    .run_btn_i     (run_btn),
    .step_btn_i    (step_btn),
    .halt_btn_i    (halt_btn),
    .restart_btn_i (restart_btn),
    .pc_i          (pc),
    .bp_en_i       (bp_en),
    .bp_addr_i     (bp_addr),
    .cpu_ce_o      (ce1),
    .cpu_reset_o   (rst1),
    .state_o       (state1),
    .bp_hit_o      (bp_hit1),
    .step_count_o  (count1)
  );

  cpu_run_controller #(.RESET_CYCLES(4), .RATE_DIV(1), .AUTO_RUN(1'b1)) dut2 (
    .clk           (clk),
    .n_sync_reset  (n_sync_reset2),
    .run_btn_i     (idle_btn),
    .step_btn_i    (idle_btn),
    .halt_btn_i    (idle_btn),
    .restart_btn_i (idle_btn),
    .pc_i          (zero16),
    .bp_en_i       (idle_bp_en),
    .bp_addr_i     (zero16),
    .cpu_ce_o      (ce2),
    .cpu_reset_o   (rst2),
    .state_o       (state2),
    .bp_hit_o      (bp_hit2),
    .step_count_o  (count2)
  );

  cpu_run_controller #(.RESET_CYCLES(4), .RATE_DIV(1), .AUTO_RUN(1'b1)) dut3 (
    .clk           (clk),
    .n_sync_reset  (n_sync_reset3),
    .run_btn_i     (idle_btn),
    .step_btn_i    (idle_btn),
    .halt_btn_i    (idle_btn),
    .restart_btn_i (idle_btn),
    .pc_i          (zero16),
    .bp_en_i       (idle_bp_en),
    .bp_addr_i     (zero16),
    .cpu_ce_o      (ce3),
    .cpu_reset_o   (rst3),
    .state_o       (state3),
    .bp_hit_o      (bp_hit3),
    .step_count_o  (count3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal core model for dut1: the PC advances on every enabled clock
  // and returns to zero while the controller holds pc_reset.
  always @(posedge clk) begin
    if (!n_sync_reset || rst1) pc <= 16'h0000;
    else if (ce1)              pc <= pc + 16'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] btns, input int hold);
    {restart_btn, halt_btn, step_btn, run_btn} = btns;
    repeat (hold) @(negedge clk);
    {restart_btn, halt_btn, step_btn, run_btn} = 4'b0000;
  endtask

  task automatic pushExp(input int unsigned at);
    exp_t e;
    exp_count = exp_count + 16'd1;
    e.cyc     = at;
    e.count   = exp_count;
    sb.push_back(e);
  endtask

  task automatic waitUntil(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard consumer: every non-reset ce pulse from dut1 must match the
  // oldest expectation; an expectation whose cycle has passed is a miss.
  always @(negedge clk) begin
    if (ce1 && !rst1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ce", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("ce_cycle", cyc, mon_e.cyc);
        checkOutput("ce_count", {16'h0, count1}, {16'h0, mon_e.count});
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checkOutput("missed_ce", cyc, mon_e.cyc);
    end
  end

  initial begin
    int unsigned p;
    int          n;
    int          hold_seen;

    n_sync_reset  = 1'b0;
    n_sync_reset2 = 1'b0;
    n_sync_reset3 = 1'b0;
    {restart_btn, halt_btn, step_btn, run_btn} = 4'b0000;
    idle_btn   = 1'b0;
    idle_bp_en = 1'b0;
    zero16     = 16'h0000;
    bp_en      = 1'b0;
    bp_addr    = 16'h0010;
    exp_count  = 16'h0000;

    repeat (3) @(negedge clk);
    checkOutput("rst_state", {30'h0, state1}, 32'd0);
    checkOutput("rst_ce", {31'h0, ce1}, 32'd1);
    checkOutput("rst_cpu_reset", {31'h0, rst1}, 32'd1);
    checkOutput("rst_bp_hit", {31'h0, bp_hit1}, 32'd0);
    checkOutput("rst_count", {16'h0, count1}, 32'd0);

    // Reset hold length after release.
    n_sync_reset = 1'b1;
    hold_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rst1 && ce1) hold_seen++;
      else break;
      @(negedge clk);
    end
    checkOutput("hold_cycles", hold_seen, 32'd4);
    checkOutput("post_hold_state", {30'h0, state1}, 32'd1);
    checkOutput("post_hold_ce", {31'h0, ce1}, 32'd0);
    checkOutput("post_hold_count", {16'h0, count1}, 32'd0);
    repeat (2) @(negedge clk);

    // Single step with the button held for 100 cycles.
    p = cyc;
    pushExp(p + 4);
    applyStimulus(B_STEP, 100);
    repeat (6) @(negedge clk);
    checkOutput("step_state", {30'h0, state1}, 32'd1);
    checkOutput("step_count", {16'h0, count1}, {16'h0, exp_count});

    // Divided RUN, then a halt whose decision lands on a ce slot.
    p = cyc;
    for (int k = 1; k <= 4; k++) pushExp(p + 4 + 5 * k);
    applyStimulus(B_RUN, 3);
    waitUntil(p + 24);
    checkOutput("run_state", {30'h0, state1}, 32'd2);
    checkOutput("run_count", {16'h0, count1}, {16'h0, exp_count});
    waitUntil(p + 25);
    applyStimulus(B_HALT, 3);
    waitUntil(p + 40);
    checkOutput("halt_state", {30'h0, state1}, 32'd1);
    checkOutput("halt_count", {16'h0, count1}, {16'h0, exp_count});

    // Breakpoint at 0x0010.
    bp_en = 1'b1;
    p = cyc;
    n = 16 - int'(pc);
    for (int k = 1; k <= n; k++) pushExp(p + 4 + 5 * k);
    applyStimulus(B_RUN, 3);
    waitUntil(p + 4 + 5 * (n + 1));
    checkOutput("bp_state", {30'h0, state1}, 32'd1);
    checkOutput("bp_hit", {31'h0, bp_hit1}, 32'd1);
    checkOutput("bp_count", {16'h0, count1}, {16'h0, exp_count});

    // Resume: the instruction at the breakpoint executes once.
    p = cyc;
    pushExp(p + 9);
    applyStimulus(B_RUN, 3);
    waitUntil(p + 4);
    checkOutput("resume_state", {30'h0, state1}, 32'd2);
    checkOutput("resume_bp_clear", {31'h0, bp_hit1}, 32'd0);
    waitUntil(p + 10);
    applyStimulus(B_HALT, 2);
    waitUntil(p + 20);
    checkOutput("resume_halt_state", {30'h0, state1}, 32'd1);
    checkOutput("resume_count", {16'h0, count1}, {16'h0, exp_count});
    bp_en = 1'b0;

    // Same-cycle halt and run from HALT: halt wins.
    p = cyc;
    applyStimulus(B_HALT | B_RUN, 3);
    waitUntil(p + 6);
    checkOutput("prio_halt_state", {30'h0, state1}, 32'd1);

    // Restart together with step and run.
    p = cyc;
    applyStimulus(B_RESTART | B_STEP | B_RUN, 3);
    waitUntil(p + 4);
    checkOutput("restart_state", {30'h0, state1}, 32'd0);
    checkOutput("restart_cpu_reset", {31'h0, rst1}, 32'd1);
    checkOutput("restart_count", {16'h0, count1}, 32'd0);
    checkOutput("restart_bp_hit", {31'h0, bp_hit1}, 32'd0);
    exp_count = 16'h0000;
    waitUntil(p + 7);
    checkOutput("restart_hold_state", {30'h0, state1}, 32'd0);
    waitUntil(p + 8);
    checkOutput("restart_done_state", {30'h0, state1}, 32'd1);
    checkOutput("restart_done_reset", {31'h0, rst1}, 32'd0);

    // Auto-run at full rate: wrap on dut2, mid-RUN reset on dut3.
    p = cyc;
    n_sync_reset2 = 1'b1;
    n_sync_reset3 = 1'b1;
    waitUntil(p + 4);
    checkOutput("auto_state", {30'h0, state2}, 32'd2);
    checkOutput("auto_reset", {31'h0, rst2}, 32'd0);
    checkOutput("auto_ce_gap", {31'h0, ce2}, 32'd0);
    waitUntil(p + 5);
    checkOutput("auto_first_ce", {31'h0, ce2}, 32'd1);
    checkOutput("auto_first_count", {16'h0, count2}, 32'd1);
    waitUntil(p + 4 + 65535);
    checkOutput("wrap_pre_count", {16'h0, count2}, 32'h0000FFFF);
    checkOutput("midrun_pre_count", {16'h0, count3}, 32'h0000FFFF);
    checkOutput("midrun_pre_state", {30'h0, state3}, 32'd2);
    n_sync_reset3 = 1'b0;
    waitUntil(p + 4 + 65536);
    checkOutput("wrap_count", {16'h0, count2}, 32'd0);
    checkOutput("wrap_ce", {31'h0, ce2}, 32'd1);
    checkOutput("wrap_state", {30'h0, state2}, 32'd2);
    checkOutput("midrun_state", {30'h0, state3}, 32'd0);
    checkOutput("midrun_ce", {31'h0, ce3}, 32'd1);
    checkOutput("midrun_reset", {31'h0, rst3}, 32'd1);
    checkOutput("midrun_count", {16'h0, count3}, 32'd0);
    checkOutput("midrun_bp_hit", {31'h0, bp_hit3}, 32'd0);

    repeat (2) @(negedge clk);
    checkOutput("sb_drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the Nandgame CPU core inside the soc wrapper.
- Generates the core's clock-enable and PC reset. Provides HALT/RUN/STEP/RESTART control from board buttons, a divided run rate so LED output stays visible, and a single PC breakpoint.
- Sits between the board buttons and the core. The core's cl is gated by cpu_ce_o; its pc_reset is driven by cpu_reset_o.

Parameters:
- RESET_CYCLES, 4, cycles cpu_reset_o is held (with cpu_ce_o=1) on entry to RESET_HOLD; must be >=1.
- RATE_DIV, 1000, RUN mode issues one cpu_ce_o pulse every RATE_DIV clk cycles; must be >=1 (1 = every cycle).
- AUTO_RUN, 0, 1: go to RUN after RESET_HOLD; 0: go to HALT.

Ports:
- clk  input  1  system clock
- n_sync_reset  input  1  synchronous active-low reset
- run_btn_i  input  1  raw button; rising edge requests RUN
- step_btn_i  input  1  raw button; rising edge requests one step
- halt_btn_i  input  1  raw button; rising edge requests HALT
- restart_btn_i  input  1  raw button; rising edge requests RESTART
- pc_i  input  16  current core PC
- bp_en_i  input  1  breakpoint enable (level)
- bp_addr_i  input  16  breakpoint address
- cpu_ce_o  output  1  core clock enable (registered)
- cpu_reset_o  output  1  core pc_reset, active-high (registered)
- state_o  output  2  ctrl_state_t encoding
- bp_hit_o  output  1  sticky breakpoint-hit flag
- step_count_o  output  16  count of non-reset ce pulses; wraps

Behaviour:
- One clock; reset is synchronous and active-low (n_sync_reset). Applied on any edge where n_sync_reset=0, including mid-RUN or mid-STEP.
- Values during reset: state=RESET_HOLD, hold counter=0, cpu_reset_o=1, cpu_ce_o=1, bp_hit_o=0, step_count_o=0, prescaler=0, skip_bp=0.
- Buttons: each passes through btn_edge (2-flop sync + rising-edge). Request pulse appears 3 clk after the raw rising edge, lasts 1 cycle. Level held high gives one request only.
- Simultaneous requests, priority: restart > halt > step > run. Lower-priority requests in the same cycle are dropped.
- States:
  - RESET_HOLD: cpu_reset_o=1, cpu_ce_o=1 for exactly RESET_CYCLES cycles. Then go to RUN if AUTO_RUN, else HALT. Outputs deassert on the transition cycle. Other requests are ignored; restart restarts the hold count.
  - HALT: cpu_ce_o=0; prescaler held at 0.
    - step request -> STEP; sets skip_bp=1.
    - run request -> RUN; sets skip_bp=1, prescaler=0.
  - STEP: exactly one cycle with cpu_ce_o=1, then HALT. Breakpoint is not checked. step_count_o increments. bp_hit_o is cleared on entry.
  - RUN: prescaler counts 0..RATE_DIV-1 and wraps. At count RATE_DIV-1 a ce slot occurs.
    - If bp_en_i && pc_i==bp_addr_i && !skip_bp: ce is suppressed, state -> HALT, bp_hit_o=1.
    - Otherwise cpu_ce_o=1 for that cycle, step_count_o increments, skip_bp clears.
    - bp_hit_o is cleared on RUN entry.
  - halt request in RUN -> HALT next cycle. A ce slot coinciding with the halt request is suppressed.
  - restart request in any state -> RESET_HOLD next cycle. Hold count restarts; step_count_o and bp_hit_o clear.
- Output timing: all outputs registered; cpu_ce_o/cpu_reset_o take effect on the cycle after the decision edge.
- Counter widths: step_count_o wraps 16'hFFFF -> 0. Prescaler width is $clog2(RATE_DIV) with a minimum of 1 bit.

Decomposition:
- Package cpu_ctrl_pkg:
  - ctrl_state_t enum, 2-bit: RESET_HOLD=0, HALT=1, RUN=2, STEP=3.
  - Request-priority constants.
- One sub-module, btn_edge: 2-flop synchroniser plus rising-edge detector, same clk/n_sync_reset. Instantiated four times.

Test Plan:
- Reset release, RESET_CYCLES=4, AUTO_RUN=0 -> cpu_reset_o=1 and cpu_ce_o=1 for exactly 4 cycles, then state_o=HALT (1), ce=0, step_count_o=0.
- HALT, step_btn pulse -> exactly one ce cycle 4 clk after the press; step_count_o=1; state returns to HALT. Button held 100 cycles -> still a single step.
- RATE_DIV=5, run pressed -> ce high 1 of every 5 cycles. After 20 cycles step_count_o=4. Halt press -> ce stops; state_o=HALT.
- RUN, bp_en_i=1, bp_addr_i=16'h0010, pc_i reaches 16'h0010 -> no ce at that slot, state_o=HALT, bp_hit_o=1. Run pressed again -> first ce executes at 0x0010, bp_hit_o clears.
- Same-cycle halt+run requests (forced) -> HALT wins. Restart with any other request -> RESET_HOLD, step_count_o=0.
- n_sync_reset=0 mid-RUN with step_count_o=16'hFFFF -> next cycle RESET_HOLD, outputs at reset values. Separately, 65536 steps from 0 -> step_count_o wraps to 0.
